// File: rtl/legv8_pkg.sv
// Shared LEGv8 control encodings: opcode patterns with don't-care masks, class and state enums,
// and the alu_op / seu field encodings driven onto the datapath.
package legv8_pkg;

    localparam int OP_BITS = 11;

    // A set mask bit means that opcode bit must match the pattern.
    localparam logic [OP_BITS-1:0] MASK_FULL = 11'b111_1111_1111;
    localparam logic [OP_BITS-1:0] MASK_I    = 11'b111_1111_1110;
    localparam logic [OP_BITS-1:0] MASK_CB   = 11'b111_1111_1000;
    localparam logic [OP_BITS-1:0] MASK_B    = 11'b111_1110_0000;

    localparam logic [OP_BITS-1:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [OP_BITS-1:0] OP_SUB  = 11'b110_0101_1000;
    localparam logic [OP_BITS-1:0] OP_AND  = 11'b100_0101_0000;
    localparam logic [OP_BITS-1:0] OP_ORR  = 11'b101_0101_0000;
    localparam logic [OP_BITS-1:0] OP_ADDI = 11'b100_1000_1000;
    localparam logic [OP_BITS-1:0] OP_SUBI = 11'b110_1000_1000;
    localparam logic [OP_BITS-1:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [OP_BITS-1:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [OP_BITS-1:0] OP_CBZ  = 11'b101_1010_0000;
    localparam logic [OP_BITS-1:0] OP_CBNZ = 11'b101_1010_1000;
    localparam logic [OP_BITS-1:0] OP_B    = 11'b000_1010_0000;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_ADD     = 4'd1,
        CLS_SUB     = 4'd2,
        CLS_AND     = 4'd3,
        CLS_ORR     = 4'd4,
        CLS_ADDI    = 4'd5,
        CLS_SUBI    = 4'd6,
        CLS_LDUR    = 4'd7,
        CLS_STUR    = 4'd8,
        CLS_CBZ     = 4'd9,
        CLS_CBNZ    = 4'd10,
        CLS_B       = 4'd11
    } cls_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [1:0] SEU_I  = 2'b00;
    localparam logic [1:0] SEU_D  = 2'b01;
    localparam logic [1:0] SEU_CB = 2'b10;
    localparam logic [1:0] SEU_B  = 2'b11;

    function automatic logic op_match(input logic [OP_BITS-1:0] op,
                                      input logic [OP_BITS-1:0] pat,
                                      input logic [OP_BITS-1:0] mask);
        return ((op ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: combinational map of the 11-bit LEGv8 opcode field to an instruction class.
// Zero latency; no handshake, anything unmatched is reported as CLS_ILLEGAL.
module opcode_decoder
    import legv8_pkg::*;
#(
    parameter int OPCODE_W = 11
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output cls_e                o_cls
);

    logic [OP_BITS-1:0] w_op;
    assign w_op = i_opcode[OP_BITS-1:0];

    always_comb begin
        o_cls = CLS_ILLEGAL;
        if      (op_match(w_op, OP_ADD,  MASK_FULL)) o_cls = CLS_ADD;
        else if (op_match(w_op, OP_SUB,  MASK_FULL)) o_cls = CLS_SUB;
        else if (op_match(w_op, OP_AND,  MASK_FULL)) o_cls = CLS_AND;
        else if (op_match(w_op, OP_ORR,  MASK_FULL)) o_cls = CLS_ORR;
        else if (op_match(w_op, OP_ADDI, MASK_I))    o_cls = CLS_ADDI;
        else if (op_match(w_op, OP_SUBI, MASK_I))    o_cls = CLS_SUBI;
        else if (op_match(w_op, OP_LDUR, MASK_FULL)) o_cls = CLS_LDUR;
        else if (op_match(w_op, OP_STUR, MASK_FULL)) o_cls = CLS_STUR;
        else if (op_match(w_op, OP_CBZ,  MASK_CB))   o_cls = CLS_CBZ;
        else if (op_match(w_op, OP_CBNZ, MASK_CB))   o_cls = CLS_CBNZ;
        else if (op_match(w_op, OP_B,    MASK_B))    o_cls = CLS_B;
    end

endmodule

// File: rtl/multicycle_cu.sv
// multicycle_cu: LEGv8 multicycle FSM control, 3-5 cycles per instruction at zero wait, Moore strobes.
// imem_req/dmem_req held until ack; perf counters exist only with MULTICYCLE_CU_PERF_EN defined.
module multicycle_cu
    import legv8_pkg::*;
#(
    parameter int OPCODE_W = 11,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_zero,
    output logic                imem_req,
    input  logic                imem_ack,
    output logic                dmem_req,
    input  logic                dmem_ack,
    output logic                ir_wr,
    output logic                pc_wr,
    output logic                pc_src,
    output logic                reg2loc,
    output logic                alu_src,
    output logic                mem_wr,
    output logic                mem_to_reg,
    output logic                reg_wr,
    output logic [1:0]          seu,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                trap,
    output logic [2:0]          state,
    output logic [CNT_W-1:0]    cyc_cnt,
    output logic [CNT_W-1:0]    ret_cnt
);

    state_e     r_state;
    state_e     w_state_nxt;
    cls_e       r_cls;
    cls_e       w_cls_dec;

    logic       w_is_ld, w_is_st, w_is_cb, w_is_b, w_taken, w_active;
    logic       w_imem_req, w_ir_wr, w_dmem_req, w_pc_wr, w_pc_src;
    logic       w_mem_wr, w_mem_to_reg, w_reg_wr, w_trap;
    logic       w_reg2loc, w_alu_src;
    logic [1:0] w_seu;
    logic [2:0] w_alu_op;

    opcode_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
        .i_opcode (opcode),
        .o_cls    (w_cls_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_cls   <= CLS_ILLEGAL;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_DECODE)
                r_cls <= w_cls_dec;
        end
    end

    assign w_is_ld  = (r_cls == CLS_LDUR);
    assign w_is_st  = (r_cls == CLS_STUR);
    assign w_is_cb  = (r_cls == CLS_CBZ) || (r_cls == CLS_CBNZ);
    assign w_is_b   = (r_cls == CLS_B);
    assign w_taken  = w_is_b || ((r_cls == CLS_CBZ) && flag_zero) || ((r_cls == CLS_CBNZ) && !flag_zero);
    assign w_active = (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB);

    // Class-static datapath strobes; only presented while an instruction is past DECODE.
    always_comb begin
        w_reg2loc = 1'b0;
        w_alu_src = 1'b0;
        w_seu     = SEU_I;
        w_alu_op  = ALU_ADD;
        case (r_cls)
            CLS_SUB:             w_alu_op = ALU_SUB;
            CLS_AND:             w_alu_op = ALU_AND;
            CLS_ORR:             w_alu_op = ALU_ORR;
            CLS_ADDI:            w_alu_src = 1'b1;
            CLS_SUBI: begin
                w_alu_src = 1'b1;
                w_alu_op  = ALU_SUB;
            end
            CLS_LDUR: begin
                w_alu_src = 1'b1;
                w_seu     = SEU_D;
            end
            CLS_STUR: begin
                w_alu_src = 1'b1;
                w_reg2loc = 1'b1;
                w_seu     = SEU_D;
            end
            CLS_CBZ, CLS_CBNZ: begin
                w_reg2loc = 1'b1;
                w_seu     = SEU_CB;
                w_alu_op  = ALU_PASSB;
            end
            CLS_B:               w_seu = SEU_B;
            default:             ;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_imem_req   = 1'b0;
        w_ir_wr      = 1'b0;
        w_dmem_req   = 1'b0;
        w_pc_wr      = 1'b0;
        w_pc_src     = 1'b0;
        w_mem_wr     = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_wr     = 1'b0;
        w_trap       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_ir_wr     = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_nxt = (w_cls_dec == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                if (w_is_cb || w_is_b) begin
                    w_pc_wr     = 1'b1;
                    w_pc_src    = w_taken;
                    w_state_nxt = ST_FETCH;
                end else if (w_is_ld || w_is_st) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                w_dmem_req = 1'b1;
                w_mem_wr   = w_is_st;
                if (dmem_ack) begin
                    w_pc_wr     = w_is_st;
                    w_state_nxt = w_is_st ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                w_reg_wr     = 1'b1;
                w_mem_to_reg = w_is_ld;
                w_pc_wr      = 1'b1;
                w_state_nxt  = ST_FETCH;
            end
            ST_TRAP: w_trap = 1'b1;
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // FETCH is the reset state, so its request must be masked while reset is held.
    assign imem_req   = w_imem_req && rst_n;
    assign ir_wr      = w_ir_wr && rst_n;
    assign dmem_req   = w_dmem_req;
    assign pc_wr      = w_pc_wr;
    assign pc_src     = w_pc_src;
    assign mem_wr     = w_mem_wr;
    assign mem_to_reg = w_mem_to_reg;
    assign reg_wr     = w_reg_wr;
    assign trap       = w_trap;
    assign reg2loc    = w_active && w_reg2loc;
    assign alu_src    = w_active && w_alu_src;
    assign seu        = w_active ? w_seu : 2'b00;
    assign alu_op     = w_active ? ALUOP_W'(w_alu_op) : '0;
    assign state      = r_state;

`ifdef MULTICYCLE_CU_PERF_EN
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_ret_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt <= '0;
            r_ret_cnt <= '0;
        end else begin
            if (r_state != ST_TRAP)
                r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            if (w_pc_wr)
                r_ret_cnt <= r_ret_cnt + CNT_W'(1);
        end
    end

    assign cyc_cnt = r_cyc_cnt;
    assign ret_cnt = r_ret_cnt;
`else
    assign cyc_cnt = '0;
    assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: per-instruction expectations queued at issue and compared at retirement,
// plus directed reset, trap and stray-handshake scenarios.
`timescale 1ns/1ps
module tb_multicycle_cu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] opcode = '0;
    logic        flag_zero = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, ir_wr, pc_wr, pc_src;
    logic        reg2loc, alu_src, mem_wr, mem_to_reg, reg_wr, trap;
    logic [1:0]  seu;
    logic [2:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] cyc_cnt, ret_cnt;

    multicycle_cu #(.OPCODE_W(11), .ALUOP_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .flag_zero(flag_zero),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src),
        .mem_wr(mem_wr), .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .seu(seu), .alu_op(alu_op),
        .trap(trap), .state(state), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

`ifdef MULTICYCLE_CU_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        int         cycles;
        int         dreq;
        int         ir_cyc;
        logic       pc_src;
        logic       reg_wr;
        logic       m2r;
        logic       mem_wr;
        logic       alu_src;
        logic       reg2loc;
        logic [2:0] alu_op;
        logic [1:0] seu;
    } rec_t;

    rec_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   exp_cyc = 0;
    int   exp_ret = 0;
    bit   exp_trap = 1'b0;

    function automatic rec_t model(input logic [10:0] op, input logic fz, input int iw, input int dw);
        rec_t e;
        e = '0;
        e.ir_cyc = iw + 1;
        casez (op)
            11'b10001011000: begin e.cycles = 4 + iw; e.reg_wr = 1; end
            11'b11001011000: begin e.cycles = 4 + iw; e.reg_wr = 1; e.alu_op = 3'b001; end
            11'b10001010000: begin e.cycles = 4 + iw; e.reg_wr = 1; e.alu_op = 3'b010; end
            11'b10101010000: begin e.cycles = 4 + iw; e.reg_wr = 1; e.alu_op = 3'b011; end
            11'b1001000100?: begin e.cycles = 4 + iw; e.reg_wr = 1; e.alu_src = 1; end
            11'b1101000100?: begin e.cycles = 4 + iw; e.reg_wr = 1; e.alu_src = 1; e.alu_op = 3'b001; end
            11'b11111000010: begin
                e.cycles = 5 + iw + dw; e.dreq = dw + 1; e.reg_wr = 1; e.m2r = 1;
                e.alu_src = 1; e.seu = 2'b01;
            end
            11'b11111000000: begin
                e.cycles = 4 + iw + dw; e.dreq = dw + 1; e.mem_wr = 1; e.reg2loc = 1;
                e.alu_src = 1; e.seu = 2'b01;
            end
            11'b10110100???: begin e.cycles = 3 + iw; e.pc_src = fz;  e.reg2loc = 1; e.seu = 2'b10; e.alu_op = 3'b100; end
            11'b10110101???: begin e.cycles = 3 + iw; e.pc_src = !fz; e.reg2loc = 1; e.seu = 2'b10; e.alu_op = 3'b100; end
            11'b000101?????: begin e.cycles = 3 + iw; e.pc_src = 1;   e.seu = 2'b11; end
            default:         e.cycles = -1;
        endcase
        return e;
    endfunction

    task automatic tick();
        if (rst_n === 1'b1 && !exp_trap) exp_cyc++;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction to retirement with the given wait states; stray=1 drives acks outside their phase.
    task automatic exec_instr(input logic [10:0] op, input logic fz, input int iw, input int dw, input bit stray);
        rec_t e;
        rec_t o;
        int   cyc = 0;
        int   iseen = 0;
        int   dseen = 0;
        int   ircnt = 0;
        bit   done = 1'b0;
        sb.push_back(model(op, fz, iw, dw));
        exp_ret++;
        o = '0;
        opcode = op;
        flag_zero = fz;
        while (!done && cyc < 200) begin
            imem_ack = imem_req ? (iseen == iw) : stray;
            dmem_ack = dmem_req ? (dseen == dw) : stray;
            #1;
            if (imem_req) iseen++;
            if (dmem_req) begin dseen++; o.dreq++; end
            if (mem_wr) o.mem_wr = 1'b1;
            if (ir_wr) begin ircnt++; o.ir_cyc = cyc + 1; end
            if (state == 3'd2) begin
                o.alu_op = alu_op; o.alu_src = alu_src; o.reg2loc = reg2loc; o.seu = seu;
            end
            if (pc_wr) begin
                done = 1'b1; o.cycles = cyc + 1; o.pc_src = pc_src; o.reg_wr = reg_wr; o.m2r = mem_to_reg;
            end
            cyc++;
            tick();
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
        end
        e = sb.pop_front();
        total++;
        if (!done) begin bad++; $display("FAIL timeout op=%b: no pc_wr within %0d cycles", op, cyc); end
        total++; if (o.cycles !== e.cycles) begin bad++; $display("FAIL cycles op=%b got %0d want %0d", op, o.cycles, e.cycles); end
        total++; if (o.ir_cyc !== e.ir_cyc || ircnt != 1) begin bad++; $display("FAIL ir_wr op=%b cycle %0d count %0d want cycle %0d count 1", op, o.ir_cyc, ircnt, e.ir_cyc); end
        total++; if (o.dreq !== e.dreq) begin bad++; $display("FAIL dmem_req op=%b got %0d cycles want %0d", op, o.dreq, e.dreq); end
        total++; if (o.pc_src !== e.pc_src) begin bad++; $display("FAIL pc_src op=%b got %b want %b", op, o.pc_src, e.pc_src); end
        total++; if (o.reg_wr !== e.reg_wr || o.m2r !== e.m2r) begin bad++; $display("FAIL reg_wr/mem_to_reg op=%b got %b%b want %b%b", op, o.reg_wr, o.m2r, e.reg_wr, e.m2r); end
        total++; if (o.mem_wr !== e.mem_wr) begin bad++; $display("FAIL mem_wr op=%b got %b want %b", op, o.mem_wr, e.mem_wr); end
        total++; if ({o.alu_op, o.alu_src, o.reg2loc, o.seu} !== {e.alu_op, e.alu_src, e.reg2loc, e.seu})
            begin bad++; $display("FAIL exec_strobes op=%b got op=%b src=%b r2l=%b seu=%b want op=%b src=%b r2l=%b seu=%b",
                op, o.alu_op, o.alu_src, o.reg2loc, o.seu, e.alu_op, e.alu_src, e.reg2loc, e.seu); end
        total++; if (state !== 3'd0 || pc_wr !== 1'b0) begin bad++; $display("FAIL post_retire op=%b state=%0d pc_wr=%b want 0 0", op, state, pc_wr); end
        total++; if (ret_cnt !== (PERF ? 32'(exp_ret) : 32'd0)) begin bad++; $display("FAIL ret_cnt op=%b got %0d want %0d", op, ret_cnt, PERF ? exp_ret : 0); end
        total++; if (cyc_cnt !== (PERF ? 32'(exp_cyc) : 32'd0)) begin bad++; $display("FAIL cyc_cnt op=%b got %0d want %0d", op, cyc_cnt, PERF ? exp_cyc : 0); end
    endtask

    task automatic test_reset();
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        #2;
        total++;
        if ({imem_req, dmem_req, ir_wr, pc_wr, reg_wr, mem_wr, trap, state, cyc_cnt, ret_cnt} !== '0) begin
            bad++; $display("FAIL reset_outputs req=%b ir_wr=%b pc_wr=%b state=%0d cyc=%0d ret=%0d want all 0",
                imem_req, ir_wr, pc_wr, state, cyc_cnt, ret_cnt);
        end
        tick();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b1 || state !== 3'd0) begin
            bad++; $display("FAIL reset_release imem_req=%b state=%0d want 1 0", imem_req, state);
        end
    endtask

    task automatic test_add();
        exec_instr(11'b10001011000, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_ldur_wait();
        exec_instr(11'b11111000010, 1'b0, 0, 2, 1'b0);
    endtask

    task automatic test_branch();
        exec_instr(11'b10110100011, 1'b1, 0, 0, 1'b0);
        exec_instr(11'b10110101000, 1'b1, 0, 0, 1'b0);
        exec_instr(11'b10110101111, 1'b0, 1, 0, 1'b0);
        exec_instr(11'b00010110110, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_stray_ack();
        exec_instr(11'b10001011000, 1'b0, 0, 0, 1'b1);
        exec_instr(11'b11111000000, 1'b0, 1, 1, 1'b1);
        exec_instr(11'b11111000010, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [10:0] ops [12];
        ops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                11'b10010001000, 11'b11010001001, 11'b11111000010, 11'b11111000000,
                11'b10110100101, 11'b10110101010, 11'b00010100001, 11'b00010111111};
        for (int i = 0; i < 24; i++) begin
            exec_instr(ops[$urandom_range(11, 0)], 1'($urandom_range(1, 0)),
                       int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic test_reset_mid();
        bit seen_pcwr = 1'b0;
        opcode = 11'b11111000000;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        total++;
        if (state !== 3'd3 || dmem_req !== 1'b1) begin bad++; $display("FAIL reach_mem state=%0d dmem_req=%b want 3 1", state, dmem_req); end
        rst_n = 1'b0;
        dmem_ack = 1'b1;
        exp_cyc = 0;
        exp_ret = 0;
        #1;
        if (pc_wr) seen_pcwr = 1'b1;
        total++;
        if ({state, dmem_req, mem_wr, cyc_cnt, ret_cnt} !== '0) begin
            bad++; $display("FAIL reset_abort state=%0d dmem_req=%b mem_wr=%b cyc=%0d ret=%0d want all 0",
                state, dmem_req, mem_wr, cyc_cnt, ret_cnt);
        end
        tick();
        rst_n = 1'b1;
        #1;
        if (pc_wr) seen_pcwr = 1'b1;
        total++;
        if (imem_req !== 1'b1 || state !== 3'd0) begin bad++; $display("FAIL release_fetch imem_req=%b state=%0d want 1 0", imem_req, state); end
        tick();
        if (pc_wr) seen_pcwr = 1'b1;
        total++;
        if (state !== 3'd0 || seen_pcwr || reg_wr !== 1'b0) begin
            bad++; $display("FAIL late_ack state=%0d pc_wr_seen=%b reg_wr=%b want 0 0 0", state, seen_pcwr, reg_wr);
        end
        total++;
        if (ret_cnt !== 32'd0 || cyc_cnt !== (PERF ? 32'(exp_cyc) : 32'd0)) begin
            bad++; $display("FAIL counters_after_abort ret=%0d cyc=%0d want 0 %0d", ret_cnt, cyc_cnt, PERF ? exp_cyc : 0);
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_trap();
        int frozen;
        opcode = 11'h7FF;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        exp_trap = 1'b1;
        frozen = exp_cyc;
        for (int i = 0; i < 10; i++) begin
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            #1;
            total++;
            if (trap !== 1'b1 || state !== 3'd5 || {imem_req, dmem_req, ir_wr, pc_wr, reg_wr, mem_wr, reg2loc, alu_src} !== '0) begin
                bad++; $display("FAIL trap_hold cycle %0d trap=%b state=%0d req=%b ir_wr=%b pc_wr=%b want 1 5 0 0 0", i, trap, state, imem_req, ir_wr, pc_wr);
            end
            tick();
        end
        total++;
        if (cyc_cnt !== (PERF ? 32'(frozen) : 32'd0)) begin bad++; $display("FAIL trap_cyc_frozen got %0d want %0d", cyc_cnt, PERF ? frozen : 0); end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n = 1'b0;
        exp_trap = 1'b0;
        exp_cyc = 0;
        exp_ret = 0;
        #1;
        total++;
        if (trap !== 1'b0 || state !== 3'd0) begin bad++; $display("FAIL trap_clear trap=%b state=%0d want 0 0", trap, state); end
        tick();
        rst_n = 1'b1;
        exec_instr(11'b11010001000, 1'b0, 1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur_wait();
        test_branch();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid();
        test_trap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_cu.md
# multicycle_cu

Multicycle control unit for the 64-bit LEGv8 core. It replaces the single-cycle combinational control unit with an FSM that sequences fetch, decode, execute, memory and writeback over several cycles. It handshakes with instruction and data memories that may insert wait states. It sits beside the datapath in the core top level, decodes the latched opcode and drives the datapath strobes, PC update and trap status.

## Interface
- `OPCODE_W`, default 11: opcode field width (instr[31:21]).
- `ALUOP_W`, default 3: ALU operation select width.
- `CNT_W`, default 32: performance counter width.
- `clk` in 1: core clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opcode` in OPCODE_W: opcode from instruction register; valid from DECODE onward.
- `flag_zero` in 1: ALU zero flag; sampled in EXEC.
- `imem_req` out 1: instruction fetch request.
- `imem_ack` in 1: instruction word valid this cycle.
- `dmem_req` out 1: data memory access request.
- `dmem_ack` in 1: data access complete / load data valid.
- `ir_wr` out 1: load instruction register.
- `pc_wr` out 1: update PC.
- `pc_src` out 1: 0 = PC+4, 1 = branch target.
- `reg2loc`, `alu_src`, `mem_wr`, `mem_to_reg`, `reg_wr` out 1 each: datapath strobes.
- `seu` out 2: immediate format. 00 = I, 01 = D, 10 = CB, 11 = B.
- `alu_op` out ALUOP_W: 000 = add, 001 = sub, 010 = and, 011 = orr, 100 = pass-B.
- `trap` out 1: illegal opcode detected; sticky.
- `state` out 3: current FSM state, for debug.
- `cyc_cnt`, `ret_cnt` out CNT_W each: performance counters.

## Operation
- Supported classes:
  - R: ADD, SUB, AND, ORR.
  - I: ADDI, SUBI.
  - D: LDUR, STUR.
  - CB: CBZ, CBNZ.
  - B.
- Any other opcode is ILLEGAL.
- States:
  - FETCH: `imem_req` = 1. On `imem_ack`, pulse `ir_wr` and go to DECODE.
  - DECODE: register opcode class into `cls_q`. ILLEGAL goes to TRAP; all others go to EXEC.
  - EXEC: ALU strobes per class.
    - R and I go to WB.
    - LDUR and STUR go to MEM.
    - CBZ: taken if `flag_zero` = 1. CBNZ: taken if `flag_zero` = 0.
    - CB and B: `pc_wr` = 1, `pc_src` = taken (B is always taken), then go to FETCH.
  - MEM: `dmem_req` = 1, with `mem_wr` = 1 for STUR.
    - On `dmem_ack`, STUR asserts `pc_wr` (`pc_src` = 0) and goes to FETCH.
    - On `dmem_ack`, LDUR goes to WB.
  - WB: `reg_wr` = 1, `mem_to_reg` = 1 for LDUR, `pc_wr` = 1, `pc_src` = 0, then go to FETCH.
  - TRAP: `trap` = 1, all strobes 0. Leaves only on reset.
- `pc_wr` asserts exactly once per retired instruction, in its final state.
- Outputs are Moore: decoded from `state` and `cls_q` only, never combinationally from `opcode`.
- `reg2loc` = 1 for STUR, CBZ, CBNZ.
- `alu_src` = 1 for I and D classes.
- `alu_op`: add for LDUR/STUR, pass-B for CB.
- `imem_ack` outside FETCH and `dmem_ack` outside MEM are ignored.

## Timing
- Reset: `state` = FETCH and every output 0 while `rst_n` is low. `imem_req` = 1 in the first cycle after release.
- Cycles with zero-wait memory (`ack` in the same cycle as `req`):
  - R/I: 4 (FETCH, DECODE, EXEC, WB).
  - LDUR: 5.
  - STUR: 4.
  - CB/B: 3.
- Each wait cycle extends FETCH or MEM by one. Request stays high until `ack`.
- Reset asserted mid-instruction aborts it immediately. No `pc_wr` or `reg_wr` is issued; a pending `ack` after reset is ignored.
- Counters wrap modulo 2^CNT_W.

## Configuration
- `MULTICYCLE_CU_PERF_EN` defined:
  - `cyc_cnt` increments every cycle while not in reset and not in TRAP.
  - `ret_cnt` increments on every `pc_wr`.
  - Both reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops exist.

## Structure
- Package `legv8_pkg` holds:
  - opcode constants (with don't-care masks for I/CB/B);
  - class enum;
  - state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP);
  - `alu_op` and `seu` encodings.
- Sub-module `opcode_decoder` is purely combinational, mapping `opcode` to class.
- The FSM and output decode live in `multicycle_cu`.

## Test plan
- ADD (10001011000), zero-wait memory -> `ir_wr` in cycle 1; `reg_wr` = 1, `pc_wr` = 1, `pc_src` = 0 in cycle 4; `ret_cnt` = 1.
- LDUR (11111000010), `dmem_ack` delayed 2 cycles -> `dmem_req` high 3 cycles, `mem_wr` = 0; WB has `mem_to_reg` = 1; 7 cycles total.
- CBZ (10110100xxx): `flag_zero` = 1 -> `pc_src` = 1. CBNZ with `flag_zero` = 1 -> `pc_src` = 0. Both 3 cycles.
- Opcode 0x7FF -> TRAP after DECODE; `trap` = 1 held 10 cycles; `cyc_cnt` frozen; `rst_n` low clears it.
- `rst_n` pulsed low during MEM of STUR -> no `pc_wr`; a late `dmem_ack` is ignored; `imem_req` = 1 the cycle after release.
- Stray `imem_ack` during EXEC -> no `ir_wr`, state unaffected.
